// File: rtl/apb2_master.sv
// APB2 bus master: converts single-beat valid/ready requests into SETUP/ACCESS
// transfers and returns one registered response (read data or write ack) per transfer.
module apb2_master #(
  parameter int unsigned ADDR_BITS  = 4,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic [DATA_BITS-1:0]  req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [DATA_BITS-1:0]  resp_rdata,
  output logic [ADDR_BITS-1:0]  PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_BITS-1:0]  PWDATA,
  input  logic [DATA_BITS-1:0]  PRDATA,
  output logic [COUNT_BITS-1:0] read_count,
  output logic [COUNT_BITS-1:0] write_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_write;
  logic [DATA_BITS-1:0]  r_resp_rdata;
  logic [ADDR_BITS-1:0]  r_paddr;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [DATA_BITS-1:0]  r_pwdata;
  logic [COUNT_BITS-1:0] r_read_count;
  logic [COUNT_BITS-1:0] r_write_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // req_ready is kept as its own flop so it is high exactly while in IDLE.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_write  <= 1'b0;
      r_resp_rdata  <= '0;
      r_paddr       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_paddr     <= req_addr;
            r_pwrite    <= req_write;
            r_pwdata    <= req_write ? req_wdata : '0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_req_ready <= 1'b0;
          end
        end
        S_SETUP: r_penable <= 1'b1;
        S_ACCESS: begin
          r_resp_rdata <= r_pwrite ? '0 : PRDATA;
          r_resp_write <= r_pwrite;
          r_resp_valid <= 1'b1;
          if (r_pwrite) r_write_count <= r_write_count + COUNT_BITS'(1);
          else          r_read_count  <= r_read_count + COUNT_BITS'(1);
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_write  = r_resp_write;
  assign resp_rdata  = r_resp_rdata;
  assign PADDR       = r_paddr;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign read_count  = r_read_count;
  assign write_count = r_write_count;

endmodule

// File: tb/tb_apb2_master.sv
// Scoreboard bench for apb2_master: APB slave memory on the bus, expected responses
// queued at issue time and checked by an independent response monitor.
module tb_apb2_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid, req_write, resp_ready;
  logic [3:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready, resp_valid, resp_write;
  logic [7:0]  resp_rdata;
  logic [3:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PWDATA, PRDATA;
  logic [15:0] read_count, write_count;

  // narrow-counter instance shares the request side and bus read data
  logic        req_ready2, resp_valid2, resp_write2;
  logic [7:0]  resp_rdata2, PWDATA2;
  logic [3:0]  PADDR2;
  logic        PSEL2, PENABLE2, PWRITE2;
  logic [1:0]  read_count2, write_count2;

  always #5 PCLK = ~PCLK;

  apb2_master #(.ADDR_BITS(4), .DATA_BITS(8), .COUNT_BITS(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA),
    .read_count(read_count), .write_count(write_count)
  );

  apb2_master #(.ADDR_BITS(4), .DATA_BITS(8), .COUNT_BITS(2)) dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_ready(resp_ready), .resp_write(resp_write2),
    .resp_rdata(resp_rdata2),
    .PADDR(PADDR2), .PSEL(PSEL2), .PENABLE(PENABLE2), .PWRITE(PWRITE2),
    .PWDATA(PWDATA2), .PRDATA(PRDATA),
    .read_count(read_count2), .write_count(write_count2)
  );

  // APB slave memory with a bench-side preload port
  logic [7:0] mem [16];
  logic       pre_we = 1'b0;
  logic [3:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  always @(posedge PCLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (PSEL && PENABLE && PWRITE) mem[PADDR] <= PWDATA;
  end
  assign PRDATA = mem[PADDR];

  typedef struct {
    logic        w;
    logic [7:0]  rd;
    logic [15:0] rc;
    logic [15:0] wc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_rc = '0;
  logic [15:0] exp_wc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: first cycle of every response is compared against the queue head.
  logic seen = 1'b0;
  always @(negedge PCLK) begin
    exp_t e;
    if (resp_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_write", {31'd0, resp_write}, {31'd0, e.w});
        chk("resp_rdata", {24'd0, resp_rdata}, {24'd0, e.rd});
        chk("resp_rdata_known", {31'd0, $isunknown(resp_rdata)}, 32'd0);
        chk("read_count", {16'd0, read_count}, {16'd0, e.rc});
        chk("write_count", {16'd0, write_count}, {16'd0, e.wc});
        chk("read_count_2bit", {30'd0, read_count2}, {30'd0, e.rc[1:0]});
      end
    end
    if (!resp_valid) seen = 1'b0;
  end

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic push_exp(input logic wr, input logic [7:0] rd);
    exp_t e;
    if (wr) exp_wc++;
    else    exp_rc++;
    e.w = wr; e.rd = rd; e.rc = exp_rc; e.wc = exp_wc;
    sb.push_back(e);
  endtask

  task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input int unsigned hold);
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    push_exp(wr, exp_rd);
    tick;
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_write = ~wr;
    chk("setup_psel", {31'd0, PSEL}, 32'd1);
    chk("setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("setup_paddr", {28'd0, PADDR}, {28'd0, a});
    chk("setup_pwdata", {24'd0, PWDATA}, wr ? {24'd0, d} : 32'd0);
    chk("setup_pwrite", {31'd0, PWRITE}, {31'd0, wr});
    chk("setup_req_ready", {31'd0, req_ready}, 32'd0);
    tick;
    chk("access_psel", {31'd0, PSEL}, 32'd1);
    chk("access_penable", {31'd0, PENABLE}, 32'd1);
    chk("access_paddr", {28'd0, PADDR}, {28'd0, a});
    chk("access_pwdata", {24'd0, PWDATA}, wr ? {24'd0, d} : 32'd0);
    tick;
    for (int unsigned i = 0; i < hold; i++) begin
      chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_resp_rdata", {24'd0, resp_rdata}, {24'd0, exp_rd});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_psel", {31'd0, PSEL}, 32'd0);
      req_valid = (i == 1);
      tick;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    tick;
    resp_ready = 1'b0;
    chk("done_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("done_req_ready", {31'd0, req_ready}, 32'd1);
    chk("done_psel", {31'd0, PSEL}, 32'd0);
    chk("done_penable", {31'd0, PENABLE}, 32'd0);
  endtask

  initial begin
    int unsigned acc;
    int unsigned bad;
    int unsigned t [3];
    logic [3:0] bb_addr [3];
    logic [7:0] bb_data [3];
    logic [3:0] rd_addr [5];
    logic [7:0] rd_exp [5];
    bb_addr = '{4'h8, 4'h9, 4'hA};
    bb_data = '{8'h11, 8'h22, 8'h33};
    rd_addr = '{4'h3, 4'h7, 4'h8, 4'h9, 4'hA};
    rd_exp  = '{8'hA5, 8'h5C, 8'h11, 8'h22, 8'h33};

    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0;
    tick; tick;
    PRESETn = 1'b1;
    chk("rst_psel", {31'd0, PSEL}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_write", {31'd0, resp_write}, 32'd0);
    chk("rst_paddr", {28'd0, PADDR}, 32'd0);
    chk("rst_pwdata", {24'd0, PWDATA}, 32'd0);
    chk("rst_resp_rdata", {24'd0, resp_rdata}, 32'd0);
    chk("rst_counts", {read_count, write_count}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    pre_we = 1'b1; pre_addr = 4'h7; pre_data = 8'h5C;
    tick;
    pre_we = 1'b0;

    xfer(1'b1, 4'h3, 8'hA5, 8'h00, 0);
    chk("mem3", {24'd0, mem[3]}, 32'h0000_00A5);
    chk("wc_after_write", {16'd0, write_count}, 32'd1);

    xfer(1'b0, 4'h7, 8'hFF, 8'h5C, 5);
    chk("rc_after_read", {16'd0, read_count}, 32'd1);

    // reset while in ACCESS drops the transfer
    req_write = 1'b1; req_addr = 4'h5; req_wdata = 8'h77; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    chk("pre_rst_penable", {31'd0, PENABLE}, 32'd1);
    PRESETn = 1'b0;
    tick;
    PRESETn = 1'b1;
    exp_rc = '0; exp_wc = '0;
    chk("rstacc_psel", {31'd0, PSEL}, 32'd0);
    chk("rstacc_penable", {31'd0, PENABLE}, 32'd0);
    chk("rstacc_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstacc_counts", {read_count, write_count}, 32'd0);
    tick;
    chk("rstacc_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstacc_resp_valid2", {31'd0, resp_valid}, 32'd0);

    // back-to-back writes with req_valid held and resp_ready tied high
    acc = 0; bad = 0;
    req_write = 1'b1; req_addr = bb_addr[0]; req_wdata = bb_data[0];
    req_valid = 1'b1; resp_ready = 1'b1;
    for (int unsigned cyc = 0; cyc < 16; cyc++) begin
      @(negedge PCLK);
      if ((resp_valid || req_ready) && PSEL) bad++;
      if (req_valid && req_ready) begin
        t[acc] = cyc;
        push_exp(1'b1, 8'h00);
        acc++;
      end
      @(posedge PCLK);
      #1;
      if (acc >= 3) req_valid = 1'b0;
      else begin
        req_addr = bb_addr[acc]; req_wdata = bb_data[acc];
      end
    end
    resp_ready = 1'b0;
    chk("b2b_accepts", acc, 32'd3);
    chk("b2b_gap1", t[1] - t[0], 32'd4);
    chk("b2b_gap2", t[2] - t[1], 32'd4);
    chk("b2b_psel_idle", bad, 32'd0);
    chk("b2b_write_count", {16'd0, write_count}, 32'd3);
    chk("b2b_mem", {8'd0, mem[8], mem[9], mem[10]}, 32'h0011_2233);

    // five reads: narrow counter wraps 1,2,3,0,1
    for (int unsigned i = 0; i < 5; i++) xfer(1'b0, rd_addr[i], 8'h00, rd_exp[i], 0);
    chk("rc_final", {16'd0, read_count}, 32'd5);
    chk("rc2_final", {30'd0, read_count2}, 32'd1);

    tick; tick;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
